// File: rtl/quicksort_core.sv
// Hardwired co-processor: push_a, pop_a and iterative Lomuto quicksort over a control block in external memory.
// One memory access outstanding at a time; scratch lives in registers and is written back before idle.
module quicksort_core #(
  parameter logic [9:0] ENTRY_PUSH = 10'h000,
  parameter logic [9:0] ENTRY_POP  = 10'h044,
  parameter logic [9:0] ENTRY_SORT = 10'h2bc
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        setb,
  output logic        idle,
  input  logic [9:0]  pc0,
  input  logic [31:0] ra0,
  input  logic [31:0] sp0,
  input  logic [31:0] a00,
  input  logic [31:0] a40,
  input  logic [31:0] a50,
  output logic [31:0] addr,
  output logic [2:0]  size,
  output logic        valid,
  output logic        write,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ready
);

  typedef enum logic [4:0] {
    S_LOAD, S_WAIT, S_DONE, S_GOT_AP, S_GOT_A, S_GOT_TOP, S_GOT_PRP, S_DISP,
    S_PU_TOP, S_PO_WA, S_PO_TOP, S_PUSH_P, S_PUSH_R, S_PUSH_NXT, S_LOOP,
    S_POP_R, S_POP_D, S_GOTX, S_PJ, S_AJ, S_AI, S_WJ, S_FIN1, S_FIN2,
    S_SPLIT, S_WB
  } state_t;

  state_t             state, ret;
  logic [9:0]         pc_q;
  logic [31:0]        cb, ra_q, sp_q, ap, prp, rd_q;
  logic signed [31:0] a_val, a_top, i, j, x, p, r, q, pr_top, aj, tmp;
  logic signed [31:0] pu_p, pu_r, sm_p, sm_r;
  logic               push2;
  logic [2:0]         wb_idx;

  logic unused_ok;
  assign unused_ok = ^{ra_q, sp_q, a40, a50};

  assign size = 3'd2;

  function automatic logic [31:0] elem(input logic [31:0] k);
    return ap + (k << 2);
  endfunction

  function automatic logic [31:0] stk(input logic [31:0] k);
    return prp + (k << 3);
  endfunction

  // Launch one access; S_WAIT returns to nxt once ready is seen.
  task automatic req(input logic [31:0] ad, input logic wr, input logic [31:0] val, input state_t nxt);
    valid <= 1'b1;
    addr  <= ad;
    write <= wr;
    wdata <= val << {ad[1:0], 3'b000};
    ret   <= nxt;
    state <= S_WAIT;
  endtask

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= S_LOAD;  ret <= S_LOAD;
      idle <= 1'b0;     valid <= 1'b0;   write <= 1'b0;
      addr <= 32'd0;    wdata <= 32'd0;  pc_q <= 10'd0;
      cb <= 32'd0;      ra_q <= 32'd0;   sp_q <= 32'd0;
      ap <= 32'd0;      prp <= 32'd0;    rd_q <= 32'd0;
      a_val <= 32'sd0;  a_top <= 32'sd0; i <= 32'sd0;  j <= 32'sd0;
      x <= 32'sd0;      p <= 32'sd0;     r <= 32'sd0;  q <= 32'sd0;
      pr_top <= 32'sd0; aj <= 32'sd0;    tmp <= 32'sd0;
      pu_p <= 32'sd0;   pu_r <= 32'sd0;  sm_p <= 32'sd0; sm_r <= 32'sd0;
      push2 <= 1'b0;    wb_idx <= 3'd0;
    end else if (!setb && !(state inside {S_LOAD, S_WAIT, S_DONE})) begin
      state <= S_LOAD;
    end else begin
      case (state)
        S_LOAD: begin
          idle <= 1'b0;
          if (!setb) begin
            pc_q <= pc0; cb <= a00; ra_q <= ra0; sp_q <= sp0;
          end else if (pc_q == ENTRY_PUSH || pc_q == ENTRY_POP || pc_q == ENTRY_SORT) begin
            req(cb, 1'b0, 32'd0, S_GOT_AP);
          end else begin
            state <= S_DONE;
          end
        end
        S_WAIT: if (ready) begin
          valid <= 1'b0;
          write <= 1'b0;
          rd_q  <= rdata;
          state <= setb ? ret : S_LOAD;
        end
        S_DONE: begin
          if (!setb) begin
            idle  <= 1'b0;
            state <= S_LOAD;
          end else begin
            idle <= 1'b1;
          end
        end
        S_GOT_AP:  begin ap <= rd_q;    req(cb + 32'd4,  1'b0, 32'd0, S_GOT_A);   end
        S_GOT_A:   begin a_val <= rd_q; req(cb + 32'd8,  1'b0, 32'd0, S_GOT_TOP); end
        S_GOT_TOP: begin a_top <= rd_q; req(cb + 32'd24, 1'b0, 32'd0, S_GOT_PRP); end
        S_GOT_PRP: begin prp <= rd_q;   state <= S_DISP; end
        S_DISP: begin
          if (pc_q == ENTRY_PUSH) begin
            req(elem(a_top), 1'b1, a_val, S_PU_TOP);
          end else if (pc_q == ENTRY_POP) begin
            req(elem(a_top), 1'b0, 32'd0, S_PO_WA);
          end else begin
            pr_top <= -32'sd1;
            pu_p   <= 32'sd0;
            pu_r   <= a_top - 32'sd1;
            push2  <= 1'b0;
            state  <= S_PUSH_P;
          end
        end
        S_PU_TOP: req(cb + 32'd8, 1'b1, a_top + 32'sd1, S_DONE);
        S_PO_WA:  begin a_val <= rd_q; req(cb + 32'd4, 1'b1, rd_q, S_PO_TOP); end
        S_PO_TOP: req(cb + 32'd8, 1'b1, a_top - 32'sd1, S_DONE);
        // Range-stack push of (pu_p, pu_r); push2 queues the smaller half on top.
        S_PUSH_P: req(stk(pr_top + 32'sd1), 1'b1, pu_p, S_PUSH_R);
        S_PUSH_R: begin
          pr_top <= pr_top + 32'sd1;
          req(stk(pr_top + 32'sd1) + 32'd4, 1'b1, pu_r, S_PUSH_NXT);
        end
        S_PUSH_NXT: begin
          if (push2) begin
            push2 <= 1'b0; pu_p <= sm_p; pu_r <= sm_r;
            state <= S_PUSH_P;
          end else begin
            state <= S_LOOP;
          end
        end
        S_LOOP: begin
          if (pr_top < 32'sd0) begin
            wb_idx <= 3'd0;
            state  <= S_WB;
          end else begin
            req(stk(pr_top), 1'b0, 32'd0, S_POP_R);
          end
        end
        S_POP_R: begin p <= rd_q; req(stk(pr_top) + 32'd4, 1'b0, 32'd0, S_POP_D); end
        S_POP_D: begin
          r      <= rd_q;
          pr_top <= pr_top - 32'sd1;
          if (p < $signed(rd_q)) req(elem(rd_q), 1'b0, 32'd0, S_GOTX);
          else state <= S_LOOP;
        end
        S_GOTX: begin x <= rd_q; i <= p - 32'sd1; j <= p; state <= S_PJ; end
        S_PJ: begin
          if (j < r) begin
            req(elem(j), 1'b0, 32'd0, S_AJ);
          end else begin
            q <= i + 32'sd1;
            req(elem(i + 32'sd1), 1'b0, 32'd0, S_FIN1);
          end
        end
        // A swap with itself changes nothing, so it is skipped.
        S_AJ: begin
          if ($signed(rd_q) <= x) begin
            aj <= rd_q;
            i  <= i + 32'sd1;
            if (i + 32'sd1 != j) begin
              req(elem(i + 32'sd1), 1'b0, 32'd0, S_AI);
            end else begin
              j <= j + 32'sd1; state <= S_PJ;
            end
          end else begin
            j <= j + 32'sd1; state <= S_PJ;
          end
        end
        S_AI:   begin tmp <= rd_q; req(elem(i), 1'b1, aj, S_WJ); end
        S_WJ:   begin j <= j + 32'sd1; req(elem(j), 1'b1, tmp, S_PJ); end
        S_FIN1: begin tmp <= rd_q; req(elem(q), 1'b1, x, S_FIN2); end
        S_FIN2: req(elem(r), 1'b1, tmp, S_SPLIT);
        S_SPLIT: begin
          push2 <= 1'b1;
          if ((q - 32'sd1 - p) > (r - q - 32'sd1)) begin
            pu_p <= p; pu_r <= q - 32'sd1; sm_p <= q + 32'sd1; sm_r <= r;
          end else begin
            pu_p <= q + 32'sd1; pu_r <= r; sm_p <= p; sm_r <= q - 32'sd1;
          end
          state <= S_PUSH_P;
        end
        S_WB: begin
          wb_idx <= wb_idx + 3'd1;
          case (wb_idx)
            3'd0:    req(cb + 32'd12, 1'b1, i,      S_WB);
            3'd1:    req(cb + 32'd16, 1'b1, j,      S_WB);
            3'd2:    req(cb + 32'd20, 1'b1, x,      S_WB);
            3'd3:    req(cb + 32'd28, 1'b1, pr_top, S_WB);
            3'd4:    req(cb + 32'd32, 1'b1, p,      S_WB);
            3'd5:    req(cb + 32'd36, 1'b1, r,      S_WB);
            default: req(cb + 32'd40, 1'b1, q,      S_DONE);
          endcase
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_quicksort_core.sv
// Bench for quicksort_core: table-driven push/pop/unknown-entry vectors, random and edge-case sorts
// against a plain insertion-sort reference, and a handshake monitor inside the memory responder.
module tb_quicksort_core;
  logic        clk = 1'b0;
  logic        rstb, setb, idle, valid, write, ready;
  logic [9:0]  pc0;
  logic [31:0] ra0, sp0, a00, a40, a50, addr, wdata, rdata;
  logic [2:0]  size;

  localparam logic [31:0] CB  = 32'h1000;
  localparam logic [31:0] PRP = 32'h1100;
  localparam logic [31:0] AP  = 32'h1200;
  localparam logic [9:0]  PUSH = 10'h000, POP = 10'h044, SORT = 10'h2bc;

  quicksort_core dut (
    .clk(clk), .rstb(rstb), .setb(setb), .idle(idle), .pc0(pc0), .ra0(ra0), .sp0(sp0),
    .a00(a00), .a40(a40), .a50(a50), .addr(addr), .size(size), .valid(valid),
    .write(write), .wdata(wdata), .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  int n_cmp = 0, n_bad = 0, req_cnt = 0;
  int ref_a [0:79];

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] top_in, a_in, slot_in, exp_a, exp_top, exp_slot;
    bit          quiet;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'h1000) >> 2);
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) &&
           ((a >= 32'h1000 && a < 32'h1030) || (a >= 32'h1100 && a < 32'h1140) ||
            (a >= 32'h1200 && a < 32'h1400));
  endfunction

  function automatic logic [31:0] hr(input logic [31:0] a);
    return mem[widx(a)];
  endfunction

  task automatic hw(input logic [31:0] a, input logic [31:0] v);
    mem[widx(a)] = v;
  endtask

  // Memory slave with random ready; also polices the request handshake.
  task automatic responder();
    bit pend = 0, prev_done = 0, lwr = 0;
    logic [31:0] la = 0, lw = 0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (!pend) begin
          chk("valid_gap", {31'd0, prev_done}, 32'd0);
          chk("size_word", {29'd0, size}, 32'd2);
          chk("addr_legal", {31'd0, legal(addr)}, 32'd1);
          req_cnt++;
          la = addr; lw = wdata; lwr = write; pend = 1;
        end else begin
          chk("hold_addr", addr, la);
          chk("hold_wdata", wdata, lw);
          chk("hold_write", {31'd0, write}, {31'd0, lwr});
        end
        ready = ($urandom_range(3) != 0);
        if (ready) begin
          pend = 0;
          if (legal(la)) begin
            if (lwr) mem[widx(la)] = lw;
            else     rdata = mem[widx(la)];
          end else begin
            rdata = 32'd0;
          end
        end
      end else begin
        ready = 1'b0;
      end
      prev_done = ready;
    end
  endtask

  task automatic run(input logic [9:0] pc);
    int cyc;
    pc0 = pc; setb = 1'b0;
    repeat (2) @(posedge clk);
    #1 setb = 1'b1;
    cyc = 0;
    while (idle !== 1'b1 && cyc < 40000) begin
      @(posedge clk); #1; cyc++;
    end
    chk("idle_reached", {31'd0, idle}, 32'd1);
  endtask

  task automatic release_run();
    setb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ref_sort(input int n);
    for (int k = 1; k < n; k++) begin
      int v, m;
      v = ref_a[k]; m = k - 1;
      while (m >= 0 && ref_a[m] > v) begin
        ref_a[m + 1] = ref_a[m]; m--;
      end
      ref_a[m + 1] = v;
    end
  endtask

  task automatic check_sorted(input int n);
    ref_sort(n);
    for (int k = 0; k < n; k++) chk("sorted_elem", hr(AP + 4 * k), ref_a[k]);
    chk("sort_atop", hr(CB + 8), n);
    chk("sort_prtop", hr(CB + 28), 32'hffffffff);
  endtask

  task automatic fill(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      logic [31:0] v;
      case (mode)
        0: v = $urandom;
        1: v = 32'h42;
        2: v = k * 3 - 100;
        3: v = 1000 - k * 7;
        default: case ($urandom_range(4))
          0: v = 32'h80000000;
          1: v = 32'h7fffffff;
          2: v = 32'hffffffff;
          3: v = 32'h1;
          default: v = 32'h0;
        endcase
      endcase
      hw(AP + 4 * k, v);
      ref_a[k] = v;
    end
    hw(AP + 4 * n, 32'ha5a5a5a5);
    hw(CB + 0, AP); hw(CB + 8, n); hw(CB + 24, PRP); hw(CB + 28, 32'h5);
  endtask

  task automatic sort_case(input int n, input int mode);
    fill(n, mode);
    run(SORT);
    release_run();
    check_sorted(n);
    chk("sort_sentinel", hr(AP + 4 * n), 32'ha5a5a5a5);
  endtask

  initial begin
    int r0, cyc;
    rstb = 1'b0; setb = 1'b0; pc0 = 10'd0; a00 = CB; ra0 = $urandom; sp0 = $urandom;
    a40 = 32'd0; a50 = 32'd0; ready = 1'b0; rdata = 32'd0;
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    tbl[0] = '{PUSH,   32'd0, 32'h12345678, 32'h0,        32'h12345678, 32'd1,        32'h12345678, 1'b0};
    tbl[1] = '{PUSH,   32'd5, 32'h80000000, 32'hffff,     32'h80000000, 32'd6,        32'h80000000, 1'b0};
    tbl[2] = '{POP,    32'd3, 32'h1111,     32'hdeadbeef, 32'hdeadbeef, 32'd2,        32'hdeadbeef, 1'b0};
    tbl[3] = '{POP,    32'd0, 32'h2222,     32'h7,        32'h7,        32'hffffffff, 32'h7,        1'b0};
    tbl[4] = '{10'h100, 32'd3, 32'hcafef00d, 32'h11,      32'hcafef00d, 32'd3,        32'h11,       1'b1};
    tbl[5] = '{10'h3ff, 32'd9, 32'h5,        32'h6,       32'h5,        32'd9,        32'h6,        1'b1};
    fork responder(); join_none

    repeat (3) @(posedge clk); #1;
    chk("rst_idle", {31'd0, idle}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    rstb = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("load_quiet", req_cnt, 0);
    chk("load_idle", {31'd0, idle}, 32'd0);

    foreach (tbl[t]) begin
      hw(CB + 0, AP); hw(CB + 4, tbl[t].a_in); hw(CB + 8, tbl[t].top_in);
      hw(AP + 4 * tbl[t].top_in, tbl[t].slot_in);
      r0 = req_cnt;
      run(tbl[t].pc);
      chk("vec_a", hr(CB + 4), tbl[t].exp_a);
      chk("vec_top", hr(CB + 8), tbl[t].exp_top);
      chk("vec_slot", hr(AP + 4 * tbl[t].top_in), tbl[t].exp_slot);
      if (tbl[t].quiet) chk("vec_no_reqs", req_cnt - r0, 0);
      release_run();
    end

    // idle holds while setb stays high, then drops one cycle after setb falls
    hw(CB + 4, 32'h55); hw(CB + 8, 32'd2);
    run(PUSH);
    @(posedge clk); #1;
    chk("idle_hold", {31'd0, idle}, 32'd1);
    setb = 1'b0;
    @(posedge clk); #1;
    chk("idle_drop", {31'd0, idle}, 32'd0);
    chk("push_slot2", hr(AP + 8), 32'h55);

    // 75 pushes, sort, then 75 pops
    hw(CB + 0, AP); hw(CB + 8, 32'd0);
    for (int k = 0; k < 75; k++) begin
      logic [31:0] v;
      v = $urandom;
      if (k % 15 == 0) v = 32'h80000000;
      if (k % 15 == 7) v = 32'h7fffffff;
      hw(CB + 4, v);
      ref_a[k] = v;
      run(PUSH);
      release_run();
    end
    chk("push75_top", hr(CB + 8), 32'd75);
    chk("push75_last", hr(AP + 4 * 74), ref_a[74]);
    hw(CB + 24, PRP); hw(CB + 28, 32'h5);
    run(SORT);
    release_run();
    check_sorted(75);
    hw(CB + 8, 32'd74);
    for (int k = 0; k < 75; k++) begin
      run(POP);
      release_run();
      chk("pop_value", hr(CB + 4), ref_a[74 - k]);
    end
    chk("pop_final_top", hr(CB + 8), 32'hffffffff);

    // setb falling mid-sort: finish the access in flight, then stay quiet
    fill(75, 3);
    pc0 = SORT;
    repeat (2) @(posedge clk);
    #1 setb = 1'b1;
    repeat (60) @(posedge clk);
    #1 setb = 1'b0;
    cyc = 0;
    while (valid !== 1'b0 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("abort_valid_drop", {31'd0, valid}, 32'd0);
    r0 = req_cnt;
    repeat (20) @(posedge clk); #1;
    chk("abort_quiet", req_cnt - r0, 0);
    chk("abort_idle", {31'd0, idle}, 32'd0);

    sort_case(0, 0);
    sort_case(1, 4);
    sort_case(2, 3);
    sort_case(75, 1);
    sort_case(75, 2);
    sort_case(75, 3);
    sort_case(40, 4);
    sort_case(33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
